// File: rtl/gpu_op_arbiter_pkg.sv
// Shared GPU op type and arbiter-wide definitions.
package gpu_op_arbiter_pkg;

    typedef enum logic [3:0] {
        OpNop    = 4'd0,
        OpSprite = 4'd1,
        OpRect   = 4'd2,
        OpDigit  = 4'd3
    } gpu_op_kind_e;

    typedef struct packed {
        gpu_op_kind_e kind;
        logic [9:0]   x;
        logic [9:0]   y;
    } gpu_op_t;

endpackage

// File: rtl/gpu_op_arbiter_round_robin_picker.sv
// Combinational round-robin picker: first set bit of req scanning ptr+1, ptr+2, ... modulo N.
module round_robin_picker #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate down so the nearest hit is written last and wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = int'(N); k >= 1; k--) begin
            cand = IDX_W'((32'(ptr) + 32'(k)) % N);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/gpu_op_arbiter.sv
// Round-robin arbiter sharing the GPU op FIFO write port; bursts stay locked to one requester.
module gpu_op_arbiter
    import gpu_op_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [N_REQ-1:0]      req_valid,
    input  gpu_op_t [N_REQ-1:0]   req_op,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output gpu_op_t               op,
    output logic                  op_wr_en,
    input  logic                  op_full,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWrite} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             burst_open_q, burst_open_d;
    logic             last_q, last_d;
    gpu_op_t          op_q, op_d;
    logic             wr_en_q, wr_en_d;
    logic [N_REQ-1:0] ready_q, ready_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    round_robin_picker #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_ptr_q     <= IDX_W'(N_REQ - 1);
            burst_open_q <= 1'b0;
            last_q       <= 1'b0;
            op_q         <= '0;
            wr_en_q      <= 1'b0;
            ready_q      <= '0;
        end else if (ce) begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_open_q <= burst_open_d;
            last_q       <= last_d;
            op_q         <= op_d;
            wr_en_q      <= wr_en_d;
            ready_q      <= ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        burst_open_d = burst_open_q;
        last_d       = last_q;
        op_d         = op_q;
        wr_en_d      = 1'b0;
        ready_d      = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (req_valid[grant_q] && !op_full) begin
                    op_d             = req_op[grant_q];
                    wr_en_d          = 1'b1;
                    ready_d[grant_q] = 1'b1;
                    last_d           = req_last[grant_q];
                    burst_open_d     = 1'b1;
                    state_d          = StWrite;
                end else if (!req_valid[grant_q] && !burst_open_q) begin
                    // Withdrawn before any write: the pointer keeps its old position.
                    state_d = StIdle;
                end
            end
            StWrite: begin
                if (last_q) begin
                    rr_ptr_d     = grant_q;
                    burst_open_d = 1'b0;
                    state_d      = StIdle;
                end else begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are masked by ce so a stalled cycle never counts as a second write.
    always_comb begin
        op        = op_q;
        op_wr_en  = wr_en_q & ce;
        req_ready = ready_q & {N_REQ{ce}};
        grant_idx = grant_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Directed self-checking bench for gpu_op_arbiter with two requesters.
module tb_gpu_op_arbiter;
    import gpu_op_arbiter_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic [1:0]    req_valid = '0;
    gpu_op_t [1:0] req_op = '0;
    logic [1:0]    req_last = '0;
    logic [1:0]    req_ready;
    gpu_op_t       op;
    logic          op_wr_en;
    logic          op_full = 1'b0;
    logic [0:0]    grant_idx;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t;
    int log_cyc[$];
    int log_idx[$];
    int log_x[$];
    int log_rdy[$];

    gpu_op_arbiter #(
        .N_REQ (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_last  (req_last),
        .req_ready (req_ready),
        .op        (op),
        .op_wr_en  (op_wr_en),
        .op_full   (op_full),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (op_wr_en) begin
            log_cyc.push_back(cyc);
            log_idx.push_back(int'(grant_idx));
            log_x.push_back(int'(op.x));
            log_rdy.push_back(int'(req_ready));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic gpu_op_t mk(input int x, input int y);
        gpu_op_t o;
        o.kind = OpSprite;
        o.x    = 10'(x);
        o.y    = 10'(y);
        return o;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ce = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_op = '0;
        op_full = 1'b0;
        tick(2);
        rst = 1'b0;
        log_cyc.delete();
        log_idx.delete();
        log_x.delete();
        log_rdy.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        req_last = 2'b11;
        req_op[0] = mk(5, 6);
        tick(2);
        checks++; if (op_wr_en !== 1'b0) begin errors++; $display("FAIL reset op_wr_en: got %b want 0", op_wr_en); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset req_ready: got %b want 00", req_ready); end
        checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL reset grant_idx: got %b want 0", grant_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (op !== '0) begin errors++; $display("FAIL reset op: got %h want 0", op); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 2'b01;
        req_last = 2'b01;
        req_op[0] = mk(20, 100);
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single busy t+1: got %b want 1", busy); end
        checks++; if (op_wr_en !== 1'b0) begin errors++; $display("FAIL single early write t+1: got %b want 0", op_wr_en); end
        tick(1);
        checks++; if (op_wr_en !== 1'b1) begin errors++; $display("FAIL single op_wr_en t+2: got %b want 1", op_wr_en); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single req_ready t+2: got %b want 01", req_ready); end
        checks++; if (op.x !== 10'd20 || op.y !== 10'd100) begin errors++; $display("FAIL single op: got x=%0d y=%0d want x=20 y=100", op.x, op.y); end
        req_valid = 2'b00;
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single busy t+4: got %b want 0", busy); end
        checks++; if (log_cyc.size() != 1) begin errors++; $display("FAIL single write count: got %0d want 1", log_cyc.size()); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 2'b11;
        req_last = 2'b11;
        req_op[0] = mk(30, 1);
        req_op[1] = mk(31, 1);
        t = cyc;
        tick(11);
        req_valid = 2'b00;
        tick(3);
        checks++; if (log_cyc.size() != 4) begin errors++; $display("FAIL rr write count: got %0d want 4", log_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < log_cyc.size()) begin
                checks++; if (log_cyc[i] != t + 2 + 3 * i) begin errors++; $display("FAIL rr cycle %0d: got %0d want %0d", i, log_cyc[i] - t, 2 + 3 * i); end
                checks++; if (log_idx[i] != i % 2) begin errors++; $display("FAIL rr grant %0d: got %0d want %0d", i, log_idx[i], i % 2); end
                checks++; if (log_x[i] != 30 + i % 2) begin errors++; $display("FAIL rr op.x %0d: got %0d want %0d", i, log_x[i], 30 + i % 2); end
                checks++; if (log_rdy[i] != (1 << (i % 2))) begin errors++; $display("FAIL rr ready %0d: got %0d want %0d", i, log_rdy[i], 1 << (i % 2)); end
            end
        end
    endtask

    task automatic test_burst_lock();
        int ec[4] = '{2, 4, 6, 9};
        int ei[4] = '{0, 0, 0, 1};
        int ex[4] = '{1, 2, 3, 9};
        do_reset();
        req_valid = 2'b11;
        req_last = 2'b10;
        req_op[0] = mk(1, 0);
        req_op[1] = mk(9, 0);
        t = cyc;
        tick(2);
        req_op[0] = mk(2, 0);
        tick(2);
        req_op[0] = mk(3, 0);
        req_last[0] = 1'b1;
        tick(2);
        req_valid[0] = 1'b0;
        tick(3);
        req_valid = 2'b00;
        tick(2);
        checks++; if (log_cyc.size() != 4) begin errors++; $display("FAIL burst write count: got %0d want 4", log_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < log_cyc.size()) begin
                checks++; if (log_cyc[i] != t + ec[i]) begin errors++; $display("FAIL burst cycle %0d: got %0d want %0d", i, log_cyc[i] - t, ec[i]); end
                checks++; if (log_idx[i] != ei[i]) begin errors++; $display("FAIL burst grant %0d: got %0d want %0d", i, log_idx[i], ei[i]); end
                checks++; if (log_x[i] != ex[i]) begin errors++; $display("FAIL burst op.x %0d: got %0d want %0d", i, log_x[i], ex[i]); end
                checks++; if (log_rdy[i] != (1 << ei[i])) begin errors++; $display("FAIL burst ready %0d: got %0d want %0d", i, log_rdy[i], 1 << ei[i]); end
            end
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        op_full = 1'b1;
        req_valid = 2'b01;
        req_last = 2'b01;
        req_op[0] = mk(5, 5);
        t = cyc;
        tick(10);
        checks++; if (log_cyc.size() != 0) begin errors++; $display("FAIL full write while full: got %0d want 0", log_cyc.size()); end
        op_full = 1'b0;
        tick(1);
        checks++; if (op_wr_en !== 1'b1) begin errors++; $display("FAIL full write after release: got %b want 1", op_wr_en); end
        req_valid = 2'b00;
        tick(3);
        checks++; if (log_cyc.size() != 1) begin errors++; $display("FAIL full write count: got %0d want 1", log_cyc.size()); end
        if (log_cyc.size() > 0) begin
            checks++; if (log_cyc[0] != t + 11) begin errors++; $display("FAIL full write cycle: got %0d want 11", log_cyc[0] - t); end
        end
    endtask

    task automatic test_withdraw_ce();
        do_reset();
        req_valid = 2'b01;
        req_last = 2'b11;
        req_op[0] = mk(40, 0);
        req_op[1] = mk(41, 0);
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL withdraw busy in issue: got %b want 1", busy); end
        req_valid = 2'b00;
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL withdraw back to idle: got %b want 0", busy); end
        req_valid = 2'b11;
        tick(2);
        checks++; if (op_wr_en !== 1'b1) begin errors++; $display("FAIL withdraw next write: got %b want 1", op_wr_en); end
        checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL withdraw rr_ptr kept: got grant %0d want 0", grant_idx); end
        checks++; if (op.x !== 10'd40) begin errors++; $display("FAIL withdraw op.x: got %0d want 40", op.x); end
        req_valid = 2'b00;
        tick(3);
        checks++; if (log_cyc.size() != 1) begin errors++; $display("FAIL withdraw write count: got %0d want 1", log_cyc.size()); end

        do_reset();
        req_valid = 2'b01;
        req_last = 2'b01;
        req_op[0] = mk(7, 0);
        t = cyc;
        tick(2);
        ce = 1'b0;
        tick(1);
        checks++; if (op_wr_en !== 1'b0) begin errors++; $display("FAIL ce stalled write: got %b want 0", op_wr_en); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ce busy held: got %b want 1", busy); end
        tick(4);
        ce = 1'b1;
        #1;
        checks++; if (op_wr_en !== 1'b1) begin errors++; $display("FAIL ce resumed write: got %b want 1", op_wr_en); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ce resumed ready: got %b want 01", req_ready); end
        req_valid = 2'b00;
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ce busy after: got %b want 0", busy); end
        checks++; if (log_cyc.size() != 1) begin errors++; $display("FAIL ce write count: got %0d want 1", log_cyc.size()); end
        if (log_cyc.size() > 0) begin
            checks++; if (log_cyc[0] != t + 7) begin errors++; $display("FAIL ce write cycle: got %0d want 7", log_cyc[0] - t); end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 2'b10;
        req_last = 2'b00;
        req_op[1] = mk(21, 0);
        t = cyc;
        tick(2);
        checks++; if (op_wr_en !== 1'b1 || grant_idx !== 1'b1) begin errors++; $display("FAIL midrst first write: got wr=%b grant=%0d want wr=1 grant=1", op_wr_en, grant_idx); end
        req_op[1] = mk(22, 0);
        req_last[1] = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        checks++; if (op_wr_en !== 1'b0) begin errors++; $display("FAIL midrst op_wr_en: got %b want 0", op_wr_en); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midrst req_ready: got %b want 00", req_ready); end
        checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL midrst grant_idx: got %0d want 0", grant_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b want 0", busy); end
        checks++; if (op !== '0) begin errors++; $display("FAIL midrst op: got %h want 0", op); end
        rst = 1'b0;
        req_valid = 2'b11;
        req_last = 2'b11;
        req_op[0] = mk(23, 0);
        tick(2);
        checks++; if (op_wr_en !== 1'b1 || grant_idx !== 1'b0) begin errors++; $display("FAIL midrst regrant: got wr=%b grant=%0d want wr=1 grant=0", op_wr_en, grant_idx); end
        checks++; if (op.x !== 10'd23) begin errors++; $display("FAIL midrst op.x: got %0d want 23", op.x); end
        req_valid = 2'b00;
        tick(3);
        checks++; if (log_cyc.size() != 2) begin errors++; $display("FAIL midrst write count: got %0d want 2", log_cyc.size()); end
        if (log_cyc.size() > 1) begin
            checks++; if (log_cyc[1] != t + 6) begin errors++; $display("FAIL midrst regrant cycle: got %0d want 6", log_cyc[1] - t); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_lock();
        test_fifo_full();
        test_withdraw_ce();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpu_op_arbiter.md
# gpu_op_arbiter

Shares the single GPU op FIFO write port among `N_REQ` op producers, e.g. game-logic FSM, score renderer and debug overlay. Selection is round-robin. A multi-op burst, such as pipe top plus bottom or a run of score digits, stays locked to one requester until it marks its last op. The block sits between the producers and the FIFO (`op`/`op_wr_en`/`op_full`), so no producer drives the FIFO directly.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, ≥1.
- `IDX_W`, default `N_REQ>1 ? $clog2(N_REQ) : 1`: width of the grant index.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high; clock clk.
- `ce`  in  1  global clock enable.
- `req_valid`  in  [N_REQ]  requester i has an op on `req_op[i]`.
- `req_op`  in  gpu_op_t [N_REQ]  op from requester i; held stable while `req_valid[i]` is high and before `req_ready[i]`.
- `req_last`  in  [N_REQ]  the presented op ends requester i's burst.
- `req_ready`  out  [N_REQ]  one-cycle pulse: op from i written to FIFO this cycle.
- `op`  out  gpu_op_t  op to FIFO.
- `op_wr_en`  out  1  FIFO write strobe.
- `op_full`  in  1  FIFO full.
- `grant_idx`  out  IDX_W  current or last granted requester.
- `busy`  out  1  a requester is granted (state ≠ IDLE).

## Operation
- **Reset values:** `op`='0, `op_wr_en`=0, `req_ready`='0, `grant_idx`=0, `busy`=0, state IDLE, `rr_ptr`=N_REQ-1 (so requester 0 wins first), `burst_open`=0.
- **ce gating:** with `ce` low, all registers hold. `op_wr_en` and `req_ready` are output as register AND `ce`, so a stall never duplicates a write.
- **IDLE:**
  - If any `req_valid`, pick the first set bit scanning `rr_ptr+1, rr_ptr+2, …` modulo N_REQ.
  - Latch it into `grant_idx`, set `busy`, go to ISSUE.
  - If no `req_valid`, stay in IDLE.
- **ISSUE:**
  - If `req_valid[g]` && `!op_full`: `op`←`req_op[g]`, `op_wr_en`←1, `req_ready[g]`←1, `last_q`←`req_last[g]`, `burst_open`←1. Go to WRITE.
  - Else if `!req_valid[g]` && `!burst_open`: the request was withdrawn before its first write. Go to IDLE; `rr_ptr` is unchanged.
  - Else wait. This covers FIFO full, or a burst that is open while the requester is between ops.
- **WRITE:**
  - Clear `op_wr_en` and `req_ready`.
  - If `last_q`: `rr_ptr`←g, `burst_open`←0, `busy`←0, go to IDLE.
  - Else return to ISSUE with the grant held.
  - `req_valid`/`req_op` are ignored in this state, which gives the requester one cycle to present its next op.
- **Other rules:**
  - Requests from other requesters never pre-empt an open burst.
  - Other requesters' `req_ready` stays 0.
  - `op` holds its last value after a write.
  - `rst` mid-burst: return to reset values immediately. A pending op is not written. A partially written burst is the requester's responsibility.

## Timing
- Grant latency: `req_valid` rises at cycle t in IDLE. ISSUE is entered at t+1, and `op_wr_en`/`req_ready` are high at t+2 if the FIFO is not full.
- Throughput: one op per 2 cycles within a burst (ISSUE, WRITE).
- Burst switch: 3 cycles from the last write of one requester to the first write of the next (WRITE, IDLE, ISSUE, write).
- `op_full` is sampled in ISSUE only. `op_full` rising in WRITE does not cancel the write already issued.
- `op` is valid in the same cycle as `op_wr_en` and is registered.

## Structure
- `gpu_op_t` comes from the existing shared `gpu_op_t.sv`.
- Define the state enum (`IDLE`, `ISSUE`, `WRITE`) locally.
- One sub-module: `round_robin_picker #(N)`. It is combinational: inputs `req[N]` and `ptr`, outputs `any` and `idx`. It is reusable for other shared resources.

## Test plan
- Single requester: N_REQ=2, `req_valid[0]` with `req_last`=1 and op x=20 y=100, FIFO empty. Expect `op_wr_en` pulse at t+2 with x=20 y=100, `req_ready[0]` in the same cycle, `busy` low at t+4.
- Round-robin: both requesters hold valid and `last`=1 continuously. Expect grant order 0,1,0,1; each write separated by 3 cycles; never two consecutive grants to the same index.
- Burst lock: requester 0 sends 3 ops (`last` on the third) while requester 1 is valid throughout. Expect three writes from 0 at 2-cycle spacing, then requester 1's write.
- FIFO full: `op_full`=1 for 10 cycles during ISSUE. Expect no `op_wr_en`; the write occurs 1 cycle after `op_full` falls; exactly one write.
- Withdraw and ce: requester drops valid in ISSUE before its first write. Expect IDLE with no write and `rr_ptr` unchanged. `ce` low for 5 cycles during WRITE: expect exactly one FIFO write.
- Reset mid-burst: assert `rst` after the first of two ops. Expect all outputs at reset values the next cycle, no further writes, and requester 0 granted first afterwards.
